// File: rtl/tcpc_i2c_master.sv
// Write-only I2C master for TCPC register access: START, address, 16-bit register, 16-bit data, STOP.
// Define TCPC_I2C_RETRY_EN to retry a NACKed frame up to three times before flagging the error.
module tcpc_i2c_master #(
  parameter int unsigned QUARTER = 31
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] reg_addr,
  input  logic [15:0] wr_data,
  input  logic        iSDA,
  output logic        SCL,
  output logic        oSDA,
  output logic        busy,
  output logic        done,
  output logic        nack
);

  localparam int unsigned QW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP
`ifdef TCPC_I2C_RETRY_EN
    , S_RETRY
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [2:0]    bitcnt;
  logic [2:0]    bytecnt;
  logic [39:0]   frame;
  logic          ack_bad;
  logic          qtick, cell_end;
  logic          accept, finish, set_nack, restart;
  logic [5:0]    bit_sel;
`ifdef TCPC_I2C_RETRY_EN
  logic [1:0]    retries;
`endif

  assign qtick    = (qcnt == QW'(QUARTER - 1));
  assign cell_end = qtick && (quarter == 2'd3);
  assign busy     = (state_q != S_IDLE);
  // Byte 0 occupies frame[39:32], byte 4 frame[7:0].
  assign bit_sel  = {3'd4 - bytecnt, bitcnt};

  always_comb begin
    state_d  = state_q;
    SCL      = 1'b1;
    oSDA     = 1'b1;
    accept   = 1'b0;
    finish   = 1'b0;
    set_nack = 1'b0;
    restart  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done) begin
          state_d = S_START;
          accept  = 1'b1;
        end
      end
      S_START: begin
        SCL  = (quarter != 2'd3);
        oSDA = (quarter < 2'd2);
        if (cell_end) state_d = S_BIT;
      end
      S_BIT: begin
        SCL  = quarter[1];
        oSDA = frame[bit_sel];
        if (cell_end && bitcnt == 3'd0) state_d = S_ACK;
      end
      S_ACK: begin
        SCL  = quarter[1];
        oSDA = 1'b1;
        if (cell_end) begin
          if (ack_bad || bytecnt == 3'd4) begin
            state_d = S_STOP;
`ifndef TCPC_I2C_RETRY_EN
            set_nack = ack_bad;
`endif
          end else begin
            state_d = S_BIT;
          end
        end
      end
      S_STOP: begin
        SCL  = (quarter != 2'd0);
        oSDA = quarter[1];
        if (cell_end) begin
`ifdef TCPC_I2C_RETRY_EN
          if (ack_bad && retries != 2'd3) begin
            state_d = S_RETRY;
          end else begin
            state_d  = S_IDLE;
            finish   = 1'b1;
            set_nack = ack_bad;
          end
`else
          state_d = S_IDLE;
          finish  = 1'b1;
`endif
        end
      end
`ifdef TCPC_I2C_RETRY_EN
      S_RETRY: begin
        if (cell_end) begin
          state_d = S_START;
          restart = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      qcnt    <= '0;
      quarter <= '0;
      bitcnt  <= '0;
      bytecnt <= '0;
      frame   <= '0;
      ack_bad <= 1'b0;
      done    <= 1'b0;
      nack    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= finish;

      if (state_q == S_IDLE || qtick) qcnt <= '0;
      else                            qcnt <= qcnt + 1'b1;

      if (state_q == S_IDLE) quarter <= '0;
      else if (qtick)        quarter <= quarter + 1'b1;

      if (accept) begin
        frame <= {dev_addr, 1'b0, reg_addr, wr_data};
        nack  <= 1'b0;
      end else if (set_nack) begin
        nack <= 1'b1;
      end

      if (state_d == S_BIT && state_q != S_BIT)            bitcnt <= 3'd7;
      else if (state_q == S_BIT && cell_end && bitcnt != 0) bitcnt <= bitcnt - 1'b1;

      if (accept || restart) bytecnt <= '0;
      else if (state_q == S_ACK && cell_end && !ack_bad && bytecnt != 3'd4)
        bytecnt <= bytecnt + 1'b1;

      if (accept || restart) ack_bad <= 1'b0;
      else if (state_q == S_ACK && quarter == 2'd3 && qcnt == '0)
        ack_bad <= iSDA;
    end
  end

`ifdef TCPC_I2C_RETRY_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset)                                        retries <= '0;
    else if (accept)                                  retries <= '0;
    else if (state_q == S_STOP && state_d == S_RETRY) retries <= retries + 1'b1;
  end
`endif

endmodule

// File: tb/tb_tcpc_i2c_master.sv
// Directed bench for tcpc_i2c_master with QUARTER=2: a bus monitor decodes SCL/oSDA and acts as the slave.
module tb_tcpc_i2c_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  dev_addr = '0;
  logic [15:0] reg_addr = '0;
  logic [15:0] wr_data = '0;
  logic        isda = 1'b1;
  logic        scl, sda, busy, done, nack;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef TCPC_I2C_RETRY_EN
  localparam int NACK_BUSY  = 376;
  localparam int NACK_TRIES = 4;
`else
  localparam int NACK_BUSY  = 88;
  localparam int NACK_TRIES = 1;
`endif

  tcpc_i2c_master #(.QUARTER(2)) dut (
    .CLK(clk), .Reset(rst), .start(start), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wr_data(wr_data), .iSDA(isda),
    .SCL(scl), .oSDA(sda), .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave
  int       cnt, n_start, n_stop, n_done, n_busy, cyc, last_rise, per_min, per_max;
  int       nack_byte = -1;
  logic [7:0] got [5];
  logic     prev_scl = 1'b1, prev_sda = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_scl = 1'b1;
      prev_sda = 1'b1;
      isda     = 1'b1;
    end else begin
      if (done) n_done++;
      if (busy) n_busy++;
      if (scl && prev_scl && prev_sda && !sda) begin
        n_start++;
        cnt = 0;
      end
      if (scl && prev_scl && !prev_sda && sda) n_stop++;
      if (scl && !prev_scl) begin
        cnt++;
        if (cnt >= 2 && cnt <= 45) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        if (cnt <= 45 && (cnt % 9) != 0)
          got[(cnt - 1) / 9] = {got[(cnt - 1) / 9][6:0], sda};
        if (cnt <= 45 && (cnt % 9) == 0)
          isda = ((cnt / 9 - 1) == nack_byte) ? 1'b1 : 1'b0;
        else
          isda = 1'b1;
      end
      prev_scl = scl;
      prev_sda = sda;
    end
  end

  task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] r, input logic [15:0] d, input int nb);
    @(negedge clk); #1;
    n_start = 0; n_stop = 0; n_done = 0; n_busy = 0;
    per_min = 1000; per_max = 0; cnt = 0; nack_byte = nb;
    for (int i = 0; i < 5; i++) got[i] = '0;
    dev_addr = 7'h7A; reg_addr = r; wr_data = d; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 3000) check("done_timeout", 40'd0, 40'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    idle(3);
    check("rst_scl", 40'(scl), 40'd1);
    check("rst_sda", 40'(sda), 40'd1);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_done", 40'(done), 40'd0);
    check("rst_nack", 40'(nack), 40'd0);
    #1 rst = 1'b0;
    idle(2);

    // Normal frame, all bytes ACKed
    launch(16'h0050, 16'h0001, -1);
    wait_done();
    check("a_b0", 40'(got[0]), 40'hF4);
    check("a_b1", 40'(got[1]), 40'h00);
    check("a_b2", 40'(got[2]), 40'h50);
    check("a_b3", 40'(got[3]), 40'h00);
    check("a_b4", 40'(got[4]), 40'h01);
    check("a_nack", 40'(nack), 40'd0);
    check("a_busy_cycles", 40'(n_busy), 40'd376);
    check("a_starts", 40'(n_start), 40'd1);
    check("a_stops", 40'(n_stop), 40'd1);
    check("a_per_min", 40'(per_min), 40'd8);
    check("a_per_max", 40'(per_max), 40'd8);
    idle(10);
    check("a_done_pulses", 40'(n_done), 40'd1);

    // Second start while busy is ignored
    launch(16'hA5C3, 16'h3C0F, -1);
    idle(40);
    #1;
    reg_addr = 16'h1234; wr_data = 16'h5678; start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    wait_done();
    check("b_b1", 40'(got[1]), 40'hA5);
    check("b_b2", 40'(got[2]), 40'hC3);
    check("b_b3", 40'(got[3]), 40'h3C);
    check("b_b4", 40'(got[4]), 40'h0F);
    idle(30);
    check("b_busy_after", 40'(busy), 40'd0);
    check("b_done_pulses", 40'(n_done), 40'd1);
    check("b_starts", 40'(n_start), 40'd1);

    // Address byte NACKed
    launch(16'h0050, 16'h0001, 0);
    wait_done();
    check("n_nack_at_done", 40'(nack), 40'd1);
    check("n_busy_cycles", 40'(n_busy), 40'(NACK_BUSY));
    check("n_starts", 40'(n_start), 40'(NACK_TRIES));
    check("n_stops", 40'(n_stop), 40'(NACK_TRIES));
    idle(10);
    check("n_nack_held", 40'(nack), 40'd1);
    check("n_done_pulses", 40'(n_done), 40'd1);

    // Accepted start clears nack; start in the done cycle is dropped
    launch(16'h0102, 16'h0304, -1);
    check("c_nack_cleared", 40'(nack), 40'd0);
    wait_done();
    #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    idle(5);
    check("c_start_on_done", 40'(busy), 40'd0);
    check("c_b4", 40'(got[4]), 40'h04);

    // Reset mid-frame takes effect without a clock edge
    launch(16'h0050, 16'h0001, -1);
    idle(60);
    #1 rst = 1'b1;
    #1;
    check("r_scl", 40'(scl), 40'd1);
    check("r_sda", 40'(sda), 40'd1);
    check("r_busy", 40'(busy), 40'd0);
    idle(2);
    #1 rst = 1'b0;
    idle(30);
    check("r_idle_busy", 40'(busy), 40'd0);
    check("r_no_done", 40'(n_done), 40'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
